ucsbece154b_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RISC-V core: generates stall/flush/forward controls,

---
 rtl/ucsbece154b_pipe_pkg.sv | 31 +++
 rtl/ucsbece154b_perf_counters.sv | 36 +++
 rtl/ucsbece154b_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_ucsbece154b_hazard_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the sequencer state encoding, the forwarding-select codes and the forwarding-priority function.
package ucsbece154b_pipe_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      IWAIT   = 2'd1,
      RECOVER = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Memory stage holds the younger result, so it wins over writeback.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       wr_m,
      input logic [4:0] rd_m,
      input logic       wr_w,
      input logic [4:0] rd_w
   );
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/ucsbece154b_perf_counters.sv
// Four saturating event counters: cycles, issued instructions, branches, mispredicts.
// Built only when PERF_CNT_EN is defined.
module ucsbece154b_perf_counters
   import ucsbece154b_pipe_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       i_inc,
   output logic [CNT_W-1:0] o_cycle,
   output logic [CNT_W-1:0] o_instr,
   output logic [CNT_W-1:0] o_br,
   output logic [CNT_W-1:0] o_miss
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cnt
         logic [CNT_W-1:0] r_cnt;
         // Hold at all-ones instead of wrapping.
         always_ff @(posedge clk) begin
            if (reset)
               r_cnt <= '0;
            else if (i_inc[gi] && (r_cnt != {CNT_W{1'b1}}))
               r_cnt <= r_cnt + 1'b1;
         end
      end
   endgenerate

   assign o_cycle = g_cnt[0].r_cnt;
   assign o_instr = g_cnt[1].r_cnt;
   assign o_br    = g_cnt[2].r_cnt;
   assign o_miss  = g_cnt[3].r_cnt;

endmodule

// File: rtl/ucsbece154b_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/forward control, misprediction redirect, imem-wait stalls.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module ucsbece154b_hazard_ctrl
   import ucsbece154b_pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             LoadE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             BranchE,
   input  logic             JumpE,
   input  logic             MispredictE,
   input  logic [XLEN-1:0]  PCTargetE,
   input  logic             ImemReady,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             RedirectF,
   output logic [XLEN-1:0]  RedirectPC,
   output logic [CNT_W-1:0] CycleCnt,
   output logic [CNT_W-1:0] InstrCnt,
   output logic [CNT_W-1:0] BrCnt,
   output logic [CNT_W-1:0] BrMissCnt
);

   state_t          r_state;
   state_t          w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;
   logic            w_lw_stall;

   assign w_lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_pc    <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
      end
   end

   always_comb begin
      StallF       = 1'b0;
      StallD       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      ForwardAE    = FWD_RF;
      ForwardBE    = FWD_RF;
      RedirectF    = 1'b0;
      RedirectPC   = '0;
      w_state_next = r_state;
      w_pc_next    = r_pc;
      if (!reset) begin
         ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
         ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
         unique case (r_state)
            RUN: begin
               // Mispredict overrides both imem wait and load-use: F must not hold.
               if (MispredictE) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
                  if (ImemReady) begin
                     RedirectF  = 1'b1;
                     RedirectPC = PCTargetE;
                  end else begin
                     w_pc_next    = PCTargetE;
                     w_state_next = RECOVER;
                  end
               end else if (!ImemReady) begin
                  StallF       = 1'b1;
                  StallD       = 1'b1;
                  FlushE       = 1'b1;
                  w_state_next = IWAIT;
               end else if (w_lw_stall) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end
            end
            IWAIT: begin
               if (!ImemReady) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end else begin
                  w_state_next = RUN;
               end
            end
            RECOVER: begin
               // The fetch in flight is on the wrong path; release F only to take the redirect.
               FlushD = 1'b1;
               if (ImemReady) begin
                  RedirectF    = 1'b1;
                  RedirectPC   = r_pc;
                  w_state_next = RUN;
               end else begin
                  StallF = 1'b1;
               end
            end
            default: w_state_next = RUN;
         endcase
      end
   end

`ifdef PERF_CNT_EN
   ucsbece154b_perf_counters #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk     (clk),
      .reset   (reset),
      .i_inc   ({MispredictE, BranchE | JumpE, ~FlushE, 1'b1}),
      .o_cycle (CycleCnt),
      .o_instr (InstrCnt),
      .o_br    (BrCnt),
      .o_miss  (BrMissCnt)
   );
`else
   logic w_unused_perf;
   assign w_unused_perf = BranchE ^ JumpE;
   assign CycleCnt  = '0;
   assign InstrCnt  = '0;
   assign BrCnt     = '0;
   assign BrMissCnt = '0;
`endif

endmodule

// File: tb/tb_ucsbece154b_hazard_ctrl.sv
// Scoreboard bench for ucsbece154b_hazard_ctrl: directed vectors push expectations, a monitor compares.
module tb_ucsbece154b_hazard_ctrl;
   import ucsbece154b_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        LoadE, RegWriteM, RegWriteW, BranchE, JumpE, MispredictE, ImemReady;
   logic [31:0] PCTargetE;
   logic        StallF, StallD, FlushD, FlushE, RedirectF;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] RedirectPC, CycleCnt, InstrCnt, BrCnt, BrMissCnt;

   ucsbece154b_hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .RdM(RdM), .RdW(RdW), .BranchE(BranchE), .JumpE(JumpE),
      .MispredictE(MispredictE), .PCTargetE(PCTargetE), .ImemReady(ImemReady),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .RedirectF(RedirectF), .RedirectPC(RedirectPC),
      .CycleCnt(CycleCnt), .InstrCnt(InstrCnt), .BrCnt(BrCnt), .BrMissCnt(BrMissCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_cnt;
      logic [40:0] ctl;
      logic [31:0] c0, c1, c2, c3;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

`ifdef PERF_CNT_EN
   localparam logic [31:0] EXP_CYC = 32'd10, EXP_INS = 32'd9, EXP_BR = 32'd1, EXP_MISS = 32'd1;
`else
   localparam logic [31:0] EXP_CYC = 32'd0, EXP_INS = 32'd0, EXP_BR = 32'd0, EXP_MISS = 32'd0;
`endif

   function automatic logic [40:0] ctl(input bit sf, sd, fd, fe, input logic [1:0] fa, fb,
                                       input bit rf, input logic [31:0] pc);
      return {sf, sd, fd, fe, fa, fb, rf, pc};
   endfunction

   task automatic ex(input string n, input logic [40:0] c);
      q.push_back('{name: n, is_cnt: 1'b0, ctl: c, c0: 32'd0, c1: 32'd0, c2: 32'd0, c3: 32'd0});
   endtask

   task automatic ex_cnt(input string n, input logic [31:0] a, b, c, d);
      q.push_back('{name: n, is_cnt: 1'b1, ctl: 41'd0, c0: a, c1: b, c2: c, c3: d});
   endtask

   // Advance one cycle and return inputs to an idle, imem-ready state.
   task automatic nxt();
      @(posedge clk);
      #1;
      reset = 1'b0;
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {LoadE, RegWriteM, RegWriteW, BranchE, JumpE, MispredictE} = '0;
      PCTargetE = 32'd0;
      ImemReady = 1'b1;
   endtask

   always @(negedge clk) begin
      logic [40:0] got;
      exp_t        e;
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (!e.is_cnt) begin
            got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, RedirectF, RedirectPC};
            if (got !== e.ctl) begin
               errors++;
               $display("FAIL %s: got sF/sD/fD/fE/fA/fB/rF/pc=%b%b%b%b/%b/%b/%b/%h want %b%b%b%b/%b/%b/%b/%h",
                        e.name, got[40], got[39], got[38], got[37], got[36:35], got[34:33], got[32], got[31:0],
                        e.ctl[40], e.ctl[39], e.ctl[38], e.ctl[37], e.ctl[36:35], e.ctl[34:33], e.ctl[32], e.ctl[31:0]);
            end else
               $display("ok   %s: ctl=%h", e.name, got);
         end else begin
            if ({CycleCnt, InstrCnt, BrCnt, BrMissCnt} !== {e.c0, e.c1, e.c2, e.c3}) begin
               errors++;
               $display("FAIL %s: got cyc/ins/br/miss=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                        e.name, CycleCnt, InstrCnt, BrCnt, BrMissCnt, e.c0, e.c1, e.c2, e.c3);
            end else
               $display("ok   %s: cyc/ins/br/miss=%0d/%0d/%0d/%0d", e.name, CycleCnt, InstrCnt, BrCnt, BrMissCnt);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset forces every output low even with hazard-triggering inputs present.
      nxt(); reset = 1'b1; ImemReady = 1'b0; MispredictE = 1'b1; PCTargetE = 32'h40;
      RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; LoadE = 1'b1; RdE = 5'd6; Rs1D = 5'd6;
      ex("reset_outputs", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));
      ex_cnt("reset_counters", 32'd0, 32'd0, 32'd0, 32'd0);
      nxt(); reset = 1'b1;

      nxt(); RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1;
      ex("fwd_mem_wins", ctl(0,0,0,0,2'b10,2'b00,0,32'h0));
      nxt(); RdW = 5'd7; RegWriteW = 1'b1; Rs2E = 5'd7; Rs1E = 5'd3;
      ex("fwd_wb_b", ctl(0,0,0,0,2'b00,2'b01,0,32'h0));
      nxt(); RdM = 5'd0; RegWriteM = 1'b1; Rs1E = 5'd0;
      ex("fwd_rd0", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));
      nxt(); RdM = 5'd5; RegWriteM = 1'b0; Rs1E = 5'd5;
      ex("fwd_no_write", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));

      nxt(); LoadE = 1'b1; RdE = 5'd6; Rs2D = 5'd6;
      ex("lw_stall", ctl(1,1,0,1,2'b00,2'b00,0,32'h0));
      nxt();
      ex("lw_release", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));
      nxt(); LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
      ex("lw_rd0", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));

      // Mispredict beats a simultaneous load-use.
      nxt(); MispredictE = 1'b1; BranchE = 1'b1; PCTargetE = 32'h40; LoadE = 1'b1; RdE = 5'd6; Rs1D = 5'd6;
      ex("mispredict_ready", ctl(0,0,1,1,2'b00,2'b00,1,32'h40));

      nxt(); ImemReady = 1'b0;
      ex("iwait_1", ctl(1,1,0,1,2'b00,2'b00,0,32'h0));
      nxt(); ImemReady = 1'b0; MispredictE = 1'b1; PCTargetE = 32'h44;
      ex("iwait_2_mispredict_ignored", ctl(1,1,0,1,2'b00,2'b00,0,32'h0));
      nxt(); ImemReady = 1'b0;
      ex("iwait_3", ctl(1,1,0,1,2'b00,2'b00,0,32'h0));
      nxt();
      ex("iwait_release", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));
      nxt(); LoadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
      ex("run_after_iwait", ctl(1,1,0,1,2'b00,2'b00,0,32'h0));

      nxt(); MispredictE = 1'b1; BranchE = 1'b1; PCTargetE = 32'h80; ImemReady = 1'b0;
      ex("recover_enter", ctl(0,0,1,1,2'b00,2'b00,0,32'h0));
      nxt(); ImemReady = 1'b0; PCTargetE = 32'h99;
      ex("recover_wait", ctl(1,0,1,0,2'b00,2'b00,0,32'h0));
      nxt(); PCTargetE = 32'h99;
      ex("recover_redirect", ctl(0,0,1,0,2'b00,2'b00,1,32'h80));
      nxt();
      ex("recover_done", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));

      nxt(); MispredictE = 1'b1; PCTargetE = 32'hC0; ImemReady = 1'b0;
      ex("rst_rec_enter", ctl(0,0,1,1,2'b00,2'b00,0,32'h0));
      nxt(); reset = 1'b1; ImemReady = 1'b0;
      ex("rst_rec_reset", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));
      nxt();
      ex("rst_rec_discard", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));
      nxt(); ImemReady = 1'b0;
      ex("rst_iwait_enter", ctl(1,1,0,1,2'b00,2'b00,0,32'h0));
      nxt(); reset = 1'b1; ImemReady = 1'b0;
      ex("rst_iwait_reset", ctl(0,0,0,0,2'b00,2'b00,0,32'h0));
      nxt(); LoadE = 1'b1; RdE = 5'd9; Rs2D = 5'd9;
      ex("rst_iwait_run", ctl(1,1,0,1,2'b00,2'b00,0,32'h0));

      // Ten counted cycles after reset with a single mispredicted branch.
      nxt(); reset = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         nxt();
         if (i == 4) begin
            BranchE = 1'b1; MispredictE = 1'b1; PCTargetE = 32'h100;
            ex("cnt_mispredict", ctl(0,0,1,1,2'b00,2'b00,1,32'h100));
         end
      end
      nxt();
      ex_cnt("perf_counters", EXP_CYC, EXP_INS, EXP_BR, EXP_MISS);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
